ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares the single-port program/data `ram` between two requesters: port 0 (CPU fetch/execute) and port 1 (program loader/debug). The block drives the RAM's enable, write_enable, addr and data_in, and returns registered read data to the winning port. Arbitration is round-robin, at most one access per cycle. An optional lock lets one port keep the RAM for back-to-back loads.

Parameters:
- ADDRESS_WIDTH, 4: significant address bits per requester.
- WIDTH, 8: data width; also the RAM address-bus width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- m0_req, m1_req  in  1 each  access request; held until granted.
- m0_we, m1_we  in  1 each  1 = write, 0 = read; held with req.
- m0_addr, m1_addr  in  ADDRESS_WIDTH each  word address; held with req.
- m0_wdata, m1_wdata  in  WIDTH each  write data; held with req.
- m0_lock, m1_lock  in  1 each  lock request; ignored unless RAM_ARB_LOCK_EN.
- m0_gnt, m1_gnt  out  1 each  combinational grant; access occurs this cycle.
- m0_rdata, m1_rdata  out  WIDTH each  registered read data.
- m0_rvalid, m1_rvalid  out  1 each  one-cycle pulse, read data valid.
- ram_enable  out  1  high in any granted cycle.
- ram_write_enable  out  1  gnt & we of the granted port.
- ram_addr  out  WIDTH  granted address, zero-extended from ADDRESS_WIDTH.
- ram_data_in  out  WIDTH  granted wdata.
- ram_data_out  in  WIDTH  combinational RAM read data.

Behaviour:
- Handshake:
  - Port asserts req with we/addr/wdata and holds them stable until its gnt=1.
  - A transfer completes in the cycle gnt=1.
  - The port may change or drop req in the next cycle.
- Grant rules:
  - At most one gnt high per cycle. No grant without req.
  - Single requester: granted the same cycle.
  - Both requesting: grant the port not granted last (register last_gnt). last_gnt updates only on a grant.
- Read latency: ram_data_out is captured into mK_rdata at the posedge ending the grant cycle; mK_rvalid=1 for exactly the following cycle.
- Writes: no rvalid; the RAM commits at the same posedge.
- rdata holds its last value when not updated.
- Idle cycles: ram_enable=0, ram_write_enable=0, ram_addr=0, ram_data_in=0.
- Address width: ram_addr upper WIDTH-ADDRESS_WIDTH bits are always 0.
- States: IDLE, OWN0, OWN1.
  - IDLE: round-robin as above.
  - OWN0/OWN1: only exist with lock (see Optional Feature). Without the macro, the FSM stays in IDLE.
- Reset (reset_n=0 at posedge):
  - State → IDLE; last_gnt → 1, so port 0 wins the first contention.
  - rdata → 0; rvalid → 0.
  - Grants are suppressed while reset_n=0.
  - Reset mid-lock releases ownership immediately.
- Simultaneous events:
  - Request and lock release in the same cycle: the release is evaluated after the grant for that cycle. The owner still gets that cycle; the other port can win from the next cycle.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - IDLE → OWNk when port k is granted with mK_lock=1.
  - In OWNk, only port k may be granted; the other port waits regardless of round-robin.
  - OWNk → IDLE at the posedge where mK_lock=0. last_gnt is still updated.
- Undefined:
  - Lock inputs are ignored and OWN states are unreachable.
  - Pure per-cycle round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1};
  - port index constants PORT_CPU=0, PORT_LOAD=1.
- Sub-module ram_arb_rr: 2-input round-robin picker (req[1:0], last_gnt → gnt[1:0]), purely combinational, reused by the top FSM.

Test Plan:
- Reset then m0 read addr 3 (RAM preloaded mem[3]=8'h2A) → m0_gnt same cycle, ram_addr=8'h03, m0_rvalid=1 and m0_rdata=8'h2A next cycle.
- m1 write addr 5 data 8'hC3, then m0 read addr 5 → ram_write_enable=1 for one cycle only; m0_rdata=8'hC3.
- m0 and m1 both request continuously for 6 cycles after reset → grants alternate 0,1,0,1,0,1; never both high.
- Both request with reset_n pulled low for one cycle mid-stream → no gnt, rvalid=0 that cycle; first grant after reset goes to m0.
- RAM_ARB_LOCK_EN: m1 locks, does 4 writes to addr 0–3 while m0 requests → m0_gnt=0 throughout; m0 granted the cycle after m1_lock drops.
- Lock macro undefined, same stimulus → grants alternate; m1_lock has no effect.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and port indices for the RAM arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int PORT_CPU = 0;
  localparam int PORT_LOAD = 1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes plus single-port RAM bus seen by the arbiter.
interface ram_arbiter_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WIDTH = 8
);
  logic m0_req, m1_req;
  logic m0_we, m1_we;
  logic [ADDRESS_WIDTH-1:0] m0_addr, m1_addr;
  logic [WIDTH-1:0] m0_wdata, m1_wdata;
  logic m0_lock, m1_lock;
  logic m0_gnt, m1_gnt;
  logic [WIDTH-1:0] m0_rdata, m1_rdata;
  logic m0_rvalid, m1_rvalid;
  logic ram_enable, ram_write_enable;
  logic [WIDTH-1:0] ram_addr, ram_data_in, ram_data_out;
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_lock, m1_lock, ram_data_out,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           ram_enable, ram_write_enable, ram_addr, ram_data_in
  );
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_lock, m1_lock, ram_data_out,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           ram_enable, ram_write_enable, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-way round-robin picker; on contention the port not granted last wins.
module ram_arb_rr (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  always_comb gnt = (req == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of a single-port RAM between CPU and loader ports.
// Define RAM_ARB_LOCK_EN to let a granted port hold the RAM while its lock is high.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset_n,
  ram_arbiter_if.slave bus
);
  state_t state, next_state;
  logic last_gnt;
  logic [1:0] req, rr_gnt, gnt;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  // An owner masks the other port out before round-robin sees it.
  always_comb req = {bus.m1_req, bus.m0_req} &
                    (state == OWN0 ? 2'b01 : state == OWN1 ? 2'b10 : 2'b11);
  ram_arb_rr u_rr (.req(req), .last_gnt(last_gnt), .gnt(rr_gnt));
  always_comb begin
    gnt = reset_n ? rr_gnt : 2'b00;
    sel_addr = gnt[PORT_LOAD] ? bus.m1_addr : gnt[PORT_CPU] ? bus.m0_addr : '0;
    bus.m0_gnt = gnt[PORT_CPU];
    bus.m1_gnt = gnt[PORT_LOAD];
    bus.ram_enable = |gnt;
    bus.ram_write_enable = gnt[PORT_LOAD] ? bus.m1_we : gnt[PORT_CPU] & bus.m0_we;
    bus.ram_addr = WIDTH'(sel_addr);
    bus.ram_data_in = gnt[PORT_LOAD] ? bus.m1_wdata : gnt[PORT_CPU] ? bus.m0_wdata : '0;
  end
`ifdef RAM_ARB_LOCK_EN
  // Release is judged after this cycle's grant, so the owner keeps its final cycle.
  always_comb next_state = state == OWN0 ? (bus.m0_lock ? OWN0 : IDLE) :
                           state == OWN1 ? (bus.m1_lock ? OWN1 : IDLE) :
                           gnt[PORT_CPU] && bus.m0_lock ? OWN0 :
                           gnt[PORT_LOAD] && bus.m1_lock ? OWN1 : IDLE;
`else
  logic unused_lock;
  assign unused_lock = bus.m0_lock ^ bus.m1_lock;
  always_comb next_state = IDLE;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
    end else begin
      state <= next_state;
      if (|gnt) last_gnt <= gnt[PORT_LOAD];
      bus.m0_rvalid <= gnt[PORT_CPU] && !bus.m0_we;
      bus.m1_rvalid <= gnt[PORT_LOAD] && !bus.m1_we;
      if (gnt[PORT_CPU] && !bus.m0_we) bus.m0_rdata <= bus.ram_data_out;
      if (gnt[PORT_LOAD] && !bus.m1_we) bus.m1_rdata <= bus.ram_data_out;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus random traffic against a transaction-level arbitration model.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int W = 8;
  typedef struct packed {
    logic we;
    logic [AW-1:0] addr;
    logic [W-1:0] wdata;
    logic lock;
  } op_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDRESS_WIDTH(AW), .WIDTH(W)) bus ();
  ram_arbiter #(.ADDRESS_WIDTH(AW), .WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [W-1:0] mem [16];
  logic pl_en = 1'b0;
  logic [3:0] pl_a = '0;
  logic [W-1:0] pl_d = '0;
  always @(posedge clk)
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.ram_enable && bus.ram_write_enable) mem[bus.ram_addr[3:0]] <= bus.ram_data_in;
  assign bus.ram_data_out = mem[bus.ram_addr[3:0]];

  int checks = 0;
  int failures = 0;
  op_t q0[$], q1[$];
  int gseq[$];
  logic [W-1:0] exp_mem [16];
  logic [W-1:0] exp_rd [2];
  logic [1:0] exp_rv = 2'b00;
  int last_port = 1;
  int owner = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int p, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic l);
    op_t o;
    o = '{we: we, addr: a, wdata: d, lock: l};
    if (p == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  task automatic step(input logic rn);
    op_t o0, o1, ow;
    logic e0, e1;
    int win;
    @(negedge clk);
    reset_n = rn;
    o0 = q0.size() > 0 ? q0[0] : '0;
    o1 = q1.size() > 0 ? q1[0] : '0;
    bus.m0_req = q0.size() > 0;
    bus.m0_we = o0.we;
    bus.m0_addr = o0.addr;
    bus.m0_wdata = o0.wdata;
    bus.m0_lock = o0.lock;
    bus.m1_req = q1.size() > 0;
    bus.m1_we = o1.we;
    bus.m1_addr = o1.addr;
    bus.m1_wdata = o1.wdata;
    bus.m1_lock = o1.lock;
    #1;
    e0 = rn && q0.size() > 0 && owner != 1;
    e1 = rn && q1.size() > 0 && owner != 0;
    win = (e0 && e1) ? (last_port == 1 ? 0 : 1) : e0 ? 0 : e1 ? 1 : -1;
    ow = win == 1 ? o1 : o0;
    check("m0_gnt", 32'(bus.m0_gnt), 32'(win == 0));
    check("m1_gnt", 32'(bus.m1_gnt), 32'(win == 1));
    check("gnt_excl", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
    check("ram_enable", 32'(bus.ram_enable), 32'(win >= 0));
    check("ram_we", 32'(bus.ram_write_enable), 32'(win >= 0 && ow.we));
    check("ram_addr", 32'(bus.ram_addr), win >= 0 ? 32'(ow.addr) : 32'd0);
    check("ram_din", 32'(bus.ram_data_in), win >= 0 ? 32'(ow.wdata) : 32'd0);
    check("m0_rvalid", 32'(bus.m0_rvalid), 32'(exp_rv[0]));
    check("m1_rvalid", 32'(bus.m1_rvalid), 32'(exp_rv[1]));
    check("m0_rdata", 32'(bus.m0_rdata), 32'(exp_rd[0]));
    check("m1_rdata", 32'(bus.m1_rdata), 32'(exp_rd[1]));
    if (!rn) begin
      last_port = 1;
      owner = -1;
      exp_rv = 2'b00;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      exp_rv = 2'b00;
      if (win >= 0) begin
        gseq.push_back(win);
        last_port = win;
        if (ow.we) exp_mem[ow.addr] = ow.wdata;
        else begin
          exp_rv[win] = 1'b1;
          exp_rd[win] = exp_mem[ow.addr];
        end
        if (win == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
`ifdef RAM_ARB_LOCK_EN
      if (owner < 0 && win >= 0 && ow.lock) owner = win;
      else if ((owner == 0 && !o0.lock) || (owner == 1 && !o1.lock)) owner = -1;
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 60) begin
      step(1'b1);
      n++;
    end
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int exp_seq[5];
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_lock = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_lock = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_a = 4'(i);
      pl_d = (i == 3) ? 8'h2A : W'($urandom);
      exp_mem[i] = pl_d;
    end
    @(negedge clk);
    pl_en = 1'b0;
    step(1'b0);

    push(0, 1'b0, 4'd3, 8'h00, 1'b0);
    step(1'b1);
    step(1'b1);
    check("tp1_rdata", 32'(bus.m0_rdata), 32'h2A);

    push(1, 1'b1, 4'd5, 8'hC3, 1'b0);
    drain();
    push(0, 1'b0, 4'd5, 8'h00, 1'b0);
    drain();
    step(1'b1);
    check("tp2_rdata", 32'(bus.m0_rdata), 32'hC3);

    step(1'b0);
    gseq.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 4'(i), 8'h00, 1'b0);
      push(1, 1'b0, 4'(i + 8), 8'h00, 1'b0);
    end
    drain();
    check("alt_len", 32'(gseq.size()), 32'd6);
    for (int i = 0; i < gseq.size(); i++) check("alt_seq", 32'(gseq[i]), 32'(i % 2));

    for (int i = 0; i < 4; i++) begin
      push(0, 1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
      push(1, 1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
    end
    step(1'b1);
    step(1'b1);
    step(1'b0);
    gseq.delete();
    drain();
    check("rst_any", 32'(gseq.size() > 0), 32'd1);
    check("rst_first", 32'(gseq.size() > 0 ? gseq[0] : -1), 32'd0);

    step(1'b0);
    gseq.delete();
    push(1, 1'b1, 4'd0, 8'h10, 1'b1);
    step(1'b1);
    push(0, 1'b0, 4'd7, 8'h00, 1'b0);
    push(1, 1'b1, 4'd1, 8'h11, 1'b1);
    push(1, 1'b1, 4'd2, 8'h12, 1'b1);
    push(1, 1'b1, 4'd3, 8'h13, 1'b0);
    drain();
`ifdef RAM_ARB_LOCK_EN
    exp_seq = '{1, 1, 1, 1, 0};
`else
    exp_seq = '{1, 0, 1, 1, 1};
`endif
    check("lock_len", 32'(gseq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gseq.size(); i++) check("lock_seq", 32'(gseq[i]), 32'(exp_seq[i]));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0 && q0.size() < 3)
        push(0, 1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(3) == 0);
      if ($urandom_range(2) == 0 && q1.size() < 3)
        push(1, 1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(3) == 0);
      step($urandom_range(40) != 0);
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
